// File: rtl/vram_slot_scheduler.sv
// vram_slot_scheduler: time-division arbiter for the single-port bitmap video RAM.
// Four 2-clock slots per 2H period: A video, B CPU-first, C DMA-first, D round-robin.
module vram_slot_scheduler #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int SLOT_D_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce2H,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    typedef enum logic [1:0] {G_NONE, G_VID, G_CPU, G_DMA} grant_t;
    grant_t            grant, grant_q;
    logic [2:0]        phase;
    logic              synced, rr_last;
    logic              access, capture;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, vid_q, cpu_q, dma_q;
    assign access  = synced && !phase[0];
    // An early ce2H kills the capture cycle it lands on; the phase-7 one is the normal boundary.
    assign capture = synced && phase[0] && !(ce2H && phase != 3'd7);
    always_comb begin
        grant = !access ? G_NONE :
                phase[2:1] == 2'd0 ? G_VID :
                phase[2:1] == 2'd1 ? (cpu_req ? G_CPU : dma_req ? G_DMA : G_NONE) :
                phase[2:1] == 2'd2 ? (dma_req ? G_DMA : cpu_req ? G_CPU : G_NONE) :
                SLOT_D_EN == 0 ? G_NONE :
                (cpu_req && dma_req) ? (rr_last ? G_DMA : G_CPU) :
                cpu_req ? G_CPU : dma_req ? G_DMA : G_NONE;
        ram_cs    = grant != G_NONE;
        ram_we    = (grant == G_CPU && cpu_we) || (grant == G_DMA && dma_we);
        ram_addr  = grant == G_VID ? vid_addr : grant == G_CPU ? cpu_addr :
                    grant == G_DMA ? dma_addr : addr_q;
        ram_wdata = grant == G_CPU ? cpu_wdata : grant == G_DMA ? dma_wdata : wdata_q;
        vid_valid = capture && grant_q == G_VID;
        cpu_ack   = capture && grant_q == G_CPU;
        dma_ack   = capture && grant_q == G_DMA;
        vid_data  = vid_valid ? ram_rdata : vid_q;
        cpu_rdata = cpu_ack ? ram_rdata : cpu_q;
        dma_rdata = dma_ack ? ram_rdata : dma_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            synced  <= 1'b0;
            rr_last <= 1'b0;
            grant_q <= G_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            vid_q   <= '0;
            cpu_q   <= '0;
            dma_q   <= '0;
        end else begin
            phase   <= ce2H ? 3'd0 : phase + 3'd1;
            synced  <= synced || ce2H;
            grant_q <= grant;
            if (grant != G_NONE) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_wdata;
            end
            // rr_last=1 means the CPU took the last contested slot D.
            if (grant != G_NONE && phase[2:1] == 2'd3 && cpu_req && dma_req)
                rr_last <= grant == G_CPU;
            if (vid_valid) vid_q <= ram_rdata;
            if (cpu_ack) cpu_q <= ram_rdata;
            if (dma_ack) dma_q <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_vram_slot_scheduler.sv
// tb_vram_slot_scheduler: directed checks of slot timing, arbitration and resync,
// with one scheduler using slot D and a second one with slot D disabled.
module tb_vram_slot_scheduler;
    logic        clk = 0, reset_n = 0, ce2H = 0;
    logic [15:0] vid_addr = 16'h1234;
    logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
    logic [15:0] cpu_addr = 0, dma_addr = 0;
    logic [7:0]  cpu_wdata = 0, dma_wdata = 0;
    logic [7:0]  vid_data, cpu_rdata, dma_rdata, ram_wdata, ram_rdata = 0;
    logic        vid_valid, cpu_ack, dma_ack, ram_cs, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  vid_data2, cpu_rdata2, dma_rdata2, ram_wdata2, ram_rdata2 = 0;
    logic        vid_valid2, cpu_ack2, dma_ack2, ram_cs2, ram_we2;
    logic [15:0] ram_addr2;
    logic [7:0]  mem1 [0:65535];
    logic [7:0]  mem2 [0:65535];
    logic [2:0]  bph = 0;
    logic        auto_ce = 0;
    int          checks = 0, failures = 0;

    always #50 clk = ~clk;

    vram_slot_scheduler #(.ADDR_W(16), .DATA_W(8), .SLOT_D_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .ce2H(ce2H), .vid_addr(vid_addr),
        .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata));

    vram_slot_scheduler #(.ADDR_W(16), .DATA_W(8), .SLOT_D_EN(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .ce2H(ce2H), .vid_addr(vid_addr),
        .vid_data(vid_data2), .vid_valid(vid_valid2),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack2), .dma_rdata(dma_rdata2),
        .ram_cs(ram_cs2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
        .ram_rdata(ram_rdata2));

    // Synchronous RAMs with one clock of read latency.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem1[ram_addr] <= ram_wdata;
            ram_rdata <= mem1[ram_addr];
        end
        if (ram_cs2) begin
            if (ram_we2) mem2[ram_addr2] <= ram_wdata2;
            ram_rdata2 <= mem2[ram_addr2];
        end
    end

    // Advance one clock; bph tracks the phase the bench has commanded via ce2H.
    task automatic cyc();
        @(posedge clk);
        #1;
        bph  = ce2H ? 3'd0 : bph + 3'd1;
        ce2H = auto_ce && bph == 3'd7;
    endtask

    task automatic go_phase(input logic [2:0] p);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bph == p) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++; if ({ram_cs, ram_we, vid_valid, cpu_ack, dma_ack} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {ram_cs, ram_we, vid_valid, cpu_ack, dma_ack}); end
        checks++; if ({ram_addr, ram_wdata, vid_data, cpu_rdata, dma_rdata} !== 48'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {ram_addr, ram_wdata, vid_data, cpu_rdata, dma_rdata}); end
        @(posedge clk);
        #1;
        reset_n = 1;
        bph = 0;
    endtask

    task automatic test_unsynced();
        logic bad;
        logic found;
        bad = 0;
        found = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        for (int i = 0; i < 20; i++) begin
            cyc();
            #1;
            if (ram_cs || cpu_ack || vid_valid || ram_cs2) bad = 1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL unsynced_quiet got=%b exp=0", bad); end
        auto_ce = 1;
        for (int i = 0; i < 8 && !ce2H; i++) cyc();
        for (int i = 0; i < 10; i++) begin
            cyc();
            #1;
            if (cpu_ack) begin
                found = 1;
                checks++; if (cpu_rdata !== 8'hA5) begin failures++; $display("FAIL first_ack_data got=%h exp=a5", cpu_rdata); end
                break;
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL first_ack_latency got=%b exp=1", found); end
        cpu_req = 0;
    endtask

    task automatic test_video();
        for (int k = 0; k < 2; k++) begin
            go_phase(0);
            #1;
            checks++; if ({ram_cs, ram_we, ram_addr} !== {2'b10, 16'h1234}) begin failures++; $display("FAIL vid_access got=%b%b_%h exp=10_1234", ram_cs, ram_we, ram_addr); end
            cyc();
            #1;
            checks++; if ({vid_valid, ram_cs, vid_data} !== {2'b10, 8'h5A}) begin failures++; $display("FAIL vid_capture got=%b%b_%h exp=10_5a", vid_valid, ram_cs, vid_data); end
            cyc();
            #1;
            checks++; if ({vid_valid, ram_cs, vid_data} !== {2'b00, 8'h5A}) begin failures++; $display("FAIL vid_idle got=%b%b_%h exp=00_5a", vid_valid, ram_cs, vid_data); end
        end
    endtask

    task automatic test_cpu_read();
        go_phase(1);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        #1;
        checks++; if (ram_cs !== 1'b0) begin failures++; $display("FAIL cpu_rd_p1_cs got=%b exp=0", ram_cs); end
        cyc();
        #1;
        checks++; if ({ram_cs, ram_we, cpu_ack, ram_addr} !== {3'b100, 16'h0040}) begin failures++; $display("FAIL cpu_rd_access got=%b%b%b_%h exp=100_0040", ram_cs, ram_we, cpu_ack, ram_addr); end
        cyc();
        #1;
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'hA5}) begin failures++; $display("FAIL cpu_rd_ack got=%b_%h exp=1_a5", cpu_ack, cpu_rdata); end
        cpu_req = 0;
        cyc();
        #1;
        checks++; if ({ram_cs, cpu_ack, cpu_rdata} !== {2'b00, 8'hA5}) begin failures++; $display("FAIL cpu_rd_hold got=%b%b_%h exp=00_a5", ram_cs, cpu_ack, cpu_rdata); end
    endtask

    task automatic test_contention();
        logic [15:0] d_addr;
        go_phase(1);
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'h11;
        dma_req = 1; dma_we = 1; dma_addr = 16'h0300; dma_wdata = 8'h22;
        for (int k = 0; k < 3; k++) begin
            d_addr = (k == 1) ? 16'h0300 : 16'h0200;
            cyc();
            #1;
            checks++; if ({ram_cs, ram_we, ram_addr, ram_wdata} !== {2'b11, 16'h0200, 8'h11}) begin failures++; $display("FAIL cont_b%0d got=%b%b_%h_%h exp=11_0200_11", k, ram_cs, ram_we, ram_addr, ram_wdata); end
            cyc();
            #1;
            checks++; if ({ram_cs, ram_we, cpu_ack, dma_ack} !== 4'b0010) begin failures++; $display("FAIL cont_b%0d_ack got=%b exp=0010", k, {ram_cs, ram_we, cpu_ack, dma_ack}); end
            cyc();
            #1;
            checks++; if ({ram_cs, ram_we, ram_addr, ram_wdata} !== {2'b11, 16'h0300, 8'h22}) begin failures++; $display("FAIL cont_c%0d got=%b%b_%h_%h exp=11_0300_22", k, ram_cs, ram_we, ram_addr, ram_wdata); end
            cyc();
            #1;
            checks++; if ({ram_we, cpu_ack, dma_ack} !== 3'b001) begin failures++; $display("FAIL cont_c%0d_ack got=%b exp=001", k, {ram_we, cpu_ack, dma_ack}); end
            cyc();
            #1;
            checks++; if ({ram_cs, ram_we, ram_addr} !== {2'b11, d_addr}) begin failures++; $display("FAIL cont_d%0d got=%b%b_%h exp=11_%h", k, ram_cs, ram_we, ram_addr, d_addr); end
            checks++; if (ram_cs2 !== 1'b0) begin failures++; $display("FAIL cont_d%0d_disabled_cs got=%b exp=0", k, ram_cs2); end
            cyc();
            #1;
            checks++; if ({cpu_ack, dma_ack} !== {k != 1, k == 1}) begin failures++; $display("FAIL cont_d%0d_ack got=%b%b exp=%b%b", k, cpu_ack, dma_ack, k != 1, k == 1); end
            checks++; if ({cpu_ack2, dma_ack2} !== 2'b00) begin failures++; $display("FAIL cont_d%0d_disabled_ack got=%b%b exp=00", k, cpu_ack2, dma_ack2); end
            cyc();
            #1;
            checks++; if ({ram_cs, ram_we, ram_addr} !== {2'b10, 16'h1234}) begin failures++; $display("FAIL cont_a%0d got=%b%b_%h exp=10_1234", k, ram_cs, ram_we, ram_addr); end
            cyc();
        end
        cyc();
        cpu_req = 0; dma_req = 0;
        #1;
        checks++; if (ram_cs !== 1'b0) begin failures++; $display("FAIL cont_dropped_cs got=%b exp=0", ram_cs); end
    endtask

    task automatic test_slot_d_disabled();
        go_phase(5);
        dma_req = 1; dma_we = 1; dma_addr = 16'h0100; dma_wdata = 8'h3C;
        cyc();
        #1;
        checks++; if (ram_cs2 !== 1'b0) begin failures++; $display("FAIL sdd_p6_cs got=%b exp=0", ram_cs2); end
        cyc();
        #1;
        checks++; if (dma_ack2 !== 1'b0) begin failures++; $display("FAIL sdd_p7_ack got=%b exp=0", dma_ack2); end
        go_phase(2);
        #1;
        checks++; if ({ram_cs2, ram_we2, ram_addr2, ram_wdata2} !== {2'b11, 16'h0100, 8'h3C}) begin failures++; $display("FAIL sdd_write got=%b%b_%h_%h exp=11_0100_3c", ram_cs2, ram_we2, ram_addr2, ram_wdata2); end
        cyc();
        #1;
        checks++; if (dma_ack2 !== 1'b1) begin failures++; $display("FAIL sdd_write_ack got=%b exp=1", dma_ack2); end
        dma_we = 0;
        cyc();
        #1;
        checks++; if ({ram_cs2, ram_we2, ram_addr2} !== {2'b10, 16'h0100}) begin failures++; $display("FAIL sdd_read got=%b%b_%h exp=10_0100", ram_cs2, ram_we2, ram_addr2); end
        cyc();
        #1;
        checks++; if ({dma_ack2, dma_rdata2} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL sdd_readback got=%b_%h exp=1_3c", dma_ack2, dma_rdata2); end
        dma_req = 0;
    endtask

    task automatic test_resync();
        go_phase(3);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0041;
        cyc();
        #1;
        checks++; if ({ram_cs, ram_addr} !== {1'b1, 16'h0041}) begin failures++; $display("FAIL resync_c_access got=%b_%h exp=1_0041", ram_cs, ram_addr); end
        ce2H = 1;
        cyc();
        #1;
        checks++; if ({cpu_ack, ram_cs, ram_addr} !== {2'b01, 16'h1234}) begin failures++; $display("FAIL resync_abort got=%b%b_%h exp=01_1234", cpu_ack, ram_cs, ram_addr); end
        cyc();
        #1;
        checks++; if ({cpu_ack, vid_valid} !== 2'b01) begin failures++; $display("FAIL resync_p1 got=%b%b exp=01", cpu_ack, vid_valid); end
        cyc();
        #1;
        checks++; if ({ram_cs, ram_addr} !== {1'b1, 16'h0041}) begin failures++; $display("FAIL resync_b_access got=%b_%h exp=1_0041", ram_cs, ram_addr); end
        cyc();
        #1;
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'hC3}) begin failures++; $display("FAIL resync_b_ack got=%b_%h exp=1_c3", cpu_ack, cpu_rdata); end
        cpu_req = 0;
    endtask

    task automatic test_reset_mid();
        go_phase(1);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        cyc();
        #1;
        checks++; if (ram_cs !== 1'b1) begin failures++; $display("FAIL rstmid_access got=%b exp=1", ram_cs); end
        reset_n = 0;
        #1;
        checks++; if ({ram_cs, cpu_ack} !== 2'b00) begin failures++; $display("FAIL rstmid_immediate got=%b exp=00", {ram_cs, cpu_ack}); end
        cyc();
        #1;
        checks++; if ({ram_cs, cpu_ack, cpu_rdata} !== {2'b00, 8'h00}) begin failures++; $display("FAIL rstmid_no_ack got=%b%b_%h exp=00_00", ram_cs, cpu_ack, cpu_rdata); end
        cpu_req = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        mem1[16'h1234] = 8'h5A; mem2[16'h1234] = 8'h5A;
        mem1[16'h0040] = 8'hA5; mem2[16'h0040] = 8'hA5;
        mem1[16'h0041] = 8'hC3; mem2[16'h0041] = 8'hC3;
        test_reset();
        test_unsynced();
        test_video();
        test_cpu_read();
        test_contention();
        test_slot_d_disabled();
        test_resync();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
